// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming parity frame checker.
// Holds the FSM state encoding, the parity-sense reducer and the frame-length width helper.
package parity_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_e;

    // Widest operand par_reduce accepts; narrower values are zero-extended, which leaves XOR unchanged.
    localparam int PAR_MAX_W = 256;

    function automatic int len_width(input int max_frame);
        return $clog2(max_frame + 1);
    endfunction

    function automatic logic par_reduce(input logic [PAR_MAX_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_word.sv
// Combinational WIDTH-bit XOR reduction of one data word (generalised 8-bit parity reducer).
// Zero latency; no flow control of its own.
module parity_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             par
);

    assign par = ^data;

endmodule

// File: rtl/parity_frame_checker.sv
// Accumulates parity over a frame closed by in_last or MAX_FRAME words, then holds the result on a valid/ready output.
// Result 1 cycle after the closing accept; input stalls while a result is pending. Optional err_cnt: PARITY_ERR_CNT_EN.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_FRAME = 16,
    parameter int ODD       = 0,
    parameter int CNT_W     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_data,
    input  logic                               in_last,
    input  logic                               in_par,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_par,
    output logic                               out_err,
    output logic                               out_ovf,
    output logic [len_width(MAX_FRAME)-1:0]    out_len
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]                   err_cnt
`endif
);

    localparam int LEN_W = len_width(MAX_FRAME);

    state_e           state_q;
    state_e           state_d;
    logic             acc_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc;
    logic             word_par;
    logic             par_f;
    logic             accept;
    logic             hit_max;
    logic             close;
    logic             ovf_d;
    logic             err_d;

    parity_word #(
        .WIDTH(WIDTH)
    ) u_word (
        .data(in_data),
        .par (word_par)
    );

    assign accept  = in_valid && (state_q == ACCUM);
    assign cnt_inc = cnt_q + LEN_W'(1);
    assign hit_max = (cnt_inc == LEN_W'(MAX_FRAME));
    assign close   = accept && (in_last || hit_max);
    assign par_f   = par_reduce(PAR_MAX_W'({acc_q, word_par}), 1'(ODD));
    assign ovf_d   = ~in_last;
    // A truncated frame never carries a valid expected parity, so only the overflow flags it.
    assign err_d   = ovf_d | (in_last & (par_f != in_par));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (close) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator is cleared at close, so it is already zero when RESULT releases to ACCUM.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            out_par <= 1'b0;
            out_err <= 1'b0;
            out_ovf <= 1'b0;
            out_len <= '0;
        end else if (close) begin
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            out_par <= par_f;
            out_err <= err_d;
            out_ovf <= ovf_d;
            out_len <= cnt_inc;
        end else if (accept) begin
            acc_q <= acc_q ^ word_par;
            cnt_q <= cnt_inc;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (close && err_d && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`else
    // Keeps CNT_W referenced when the counter is compiled out.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Three checker instances (even/16, even/4, odd/16 with 2-bit counter) driven by directed and random frames.
module tb_parity_frame_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       [3];
    logic       in_valid  [3];
    logic [7:0] in_data   [3];
    logic       in_last   [3];
    logic       in_par    [3];
    logic       out_ready [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       out_par   [3];
    logic       out_err   [3];
    logic       out_ovf   [3];
    logic [4:0] out_len   [3];
`ifdef PARITY_ERR_CNT_EN
    logic [15:0] err_cnt  [3];
`endif

    int vectors     = 0;
    int miscompares = 0;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int MF = (g == 1) ? 4 : 16;
        localparam int OD = (g == 2) ? 1 : 0;
        localparam int CW = (g == 2) ? 2 : 16;
        localparam int LW = $clog2(MF + 1);
        logic [LW-1:0] len_l;
`ifdef PARITY_ERR_CNT_EN
        logic [CW-1:0] cnt_l;
        assign err_cnt[g] = 16'(cnt_l);
`endif
        parity_frame_checker #(
            .WIDTH(8), .MAX_FRAME(MF), .ODD(OD), .CNT_W(CW)
        ) dut (
            .clk      (clk),
            .rst      (rst[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .in_last  (in_last[g]),
            .in_par   (in_par[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_par  (out_par[g]),
            .out_err  (out_err[g]),
            .out_ovf  (out_ovf[g]),
            .out_len  (len_l)
`ifdef PARITY_ERR_CNT_EN
            ,
            .err_cnt  (cnt_l)
`endif
        );
        assign out_len[g] = 5'(len_l);
    end

    function automatic int mf(input int g);
        return (g == 1) ? 4 : 16;
    endfunction

    function automatic int od(input int g);
        return (g == 2) ? 1 : 0;
    endfunction

    function automatic int cmax(input int g);
        return (g == 2) ? 3 : 65535;
    endfunction

    // Reference model: words of the open frame, pending result and the counter.
    bit         m_pend  [3];
    bit         m_fresh [3];
    logic [7:0] m_w     [3][16];
    int         m_n     [3];
    int         e_par   [3];
    int         e_err   [3];
    int         e_ovf   [3];
    int         e_len   [3];
    int         e_cnt   [3];

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %0d, want %0d at %0t", name, g, act, exp, $time);
        end
    endtask

    task automatic model_advance(input int g);
        int ones;
        if (rst[g]) begin
            m_pend[g] = 0; m_fresh[g] = 1; m_n[g] = 0;
            e_par[g] = 0; e_err[g] = 0; e_ovf[g] = 0; e_len[g] = 0; e_cnt[g] = 0;
        end else if (m_pend[g]) begin
            if (out_ready[g]) m_pend[g] = 0;
        end else if (in_valid[g]) begin
            m_w[g][m_n[g]] = in_data[g];
            m_n[g]++;
            if (in_last[g] || m_n[g] == mf(g)) begin
                ones = 0;
                for (int i = 0; i < m_n[g]; i++) ones += $countones(m_w[g][i]);
                e_par[g] = (ones % 2) ^ od(g);
                e_len[g] = m_n[g];
                e_ovf[g] = in_last[g] ? 0 : 1;
                e_err[g] = (e_ovf[g] == 1 || e_par[g] != int'(in_par[g])) ? 1 : 0;
                if (e_err[g] == 1 && e_cnt[g] < cmax(g)) e_cnt[g]++;
                m_pend[g] = 1; m_fresh[g] = 0; m_n[g] = 0;
            end
        end
    endtask

    task automatic compare(input int g);
        chk("in_ready", g, 32'(in_ready[g]), 32'(!m_pend[g]));
        chk("out_valid", g, 32'(out_valid[g]), 32'(m_pend[g]));
        if (m_pend[g] || m_fresh[g]) begin
            chk("out_par", g, 32'(out_par[g]), e_par[g]);
            chk("out_err", g, 32'(out_err[g]), e_err[g]);
            chk("out_ovf", g, 32'(out_ovf[g]), e_ovf[g]);
            chk("out_len", g, 32'(out_len[g]), e_len[g]);
        end
`ifdef PARITY_ERR_CNT_EN
        chk("err_cnt", g, 32'(err_cnt[g]), e_cnt[g]);
`endif
    endtask

    task automatic step();
        for (int g = 0; g < 3; g++) model_advance(g);
        @(negedge clk);
        for (int g = 0; g < 3; g++) compare(g);
    endtask

    task automatic send(input int g, input logic [7:0] d, input logic l, input logic p);
        int budget = 20;
        out_ready[g] = 1'b1;
        in_valid[g] = 1'b1; in_data[g] = d; in_last[g] = l; in_par[g] = p;
        while (m_pend[g] && budget > 0) begin
            step();
            budget--;
        end
        chk("send_budget", g, 32'(budget > 0), 32'd1);
        step();
        in_valid[g] = 1'b0; in_last[g] = 1'b0; in_par[g] = 1'b0;
    endtask

    task automatic pin(input int g, input int p, input int e, input int o, input int len);
        chk("pin_valid", g, 32'(out_valid[g]), 32'd1);
        chk("pin_par", g, 32'(out_par[g]), p);
        chk("pin_err", g, 32'(out_err[g]), e);
        chk("pin_ovf", g, 32'(out_ovf[g]), o);
        chk("pin_len", g, 32'(out_len[g]), len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b1; in_valid[g] = 1'b0; in_data[g] = '0;
            in_last[g] = 1'b0; in_par[g] = 1'b0; out_ready[g] = 1'b1;
        end
        step();
        step();
        for (int g = 0; g < 3; g++) rst[g] = 1'b0;
        step();
        chk("rst_in_ready", 0, 32'(in_ready[0]), 32'd1);
        chk("rst_out_valid", 0, 32'(out_valid[0]), 32'd0);

        // Reset mid-frame discards the partial frame.
        send(0, 8'hA5, 1'b0, 1'b0);
        send(0, 8'h01, 1'b0, 1'b0);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("no_result_after_rst", 0, 32'(out_valid[0]), 32'd0);
        end
        send(0, 8'h03, 1'b1, 1'b0);
        pin(0, 0, 0, 0, 1);

        send(0, 8'hFF, 1'b0, 1'b0);
        send(0, 8'h01, 1'b0, 1'b0);
        send(0, 8'h80, 1'b1, 1'b0);
        pin(0, 0, 0, 0, 3);

        // Odd sense mismatch.
        send(2, 8'h07, 1'b1, 1'b1);
        pin(2, 0, 1, 0, 1);
`ifdef PARITY_ERR_CNT_EN
        chk("err_cnt_first", 2, 32'(err_cnt[2]), 32'd1);
`endif

        // Overflow at MAX_FRAME=4, then the 5th word opens a new frame.
        for (int k = 0; k < 4; k++) send(1, 8'h01, 1'b0, 1'b0);
        pin(1, 0, 1, 1, 4);
        send(1, 8'h01, 1'b0, 1'b0);
        send(1, 8'h00, 1'b1, 1'b1);
        pin(1, 1, 0, 0, 2);

        // Backpressure: result held, incoming words refused.
        send(0, 8'h01, 1'b1, 1'b1);
        pin(0, 1, 0, 0, 1);
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1; in_data[0] = 8'h55; in_last[0] = 1'b1; in_par[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_in_ready", 0, 32'(in_ready[0]), 32'd0);
            pin(0, 1, 0, 0, 1);
        end
        out_ready[0] = 1'b1;
        step();
        chk("bp_release_in_ready", 0, 32'(in_ready[0]), 32'd1);
        chk("bp_release_valid", 0, 32'(out_valid[0]), 32'd0);
        in_valid[0] = 1'b0; in_last[0] = 1'b0;
        step();

        // Counter saturation on the 2-bit instance: continues 1 -> 2, 3, 3, 3.
        for (int k = 0; k < 4; k++) begin
            send(2, 8'h07, 1'b1, 1'b1);
            pin(2, 0, 1, 0, 1);
`ifdef PARITY_ERR_CNT_EN
            chk("err_cnt_sat", 2, 32'(err_cnt[2]), (k == 0) ? 32'd2 : 32'd3);
`endif
        end
        step();

        for (int c = 0; c < 4000; c++) begin
            for (int g = 0; g < 3; g++) begin
                rst[g]       = ($urandom_range(0, 149) == 0);
                in_valid[g]  = ($urandom_range(0, 3) != 0);
                in_data[g]   = 8'($urandom);
                in_last[g]   = ($urandom_range(0, 3) == 0);
                in_par[g]    = 1'($urandom);
                out_ready[g] = ($urandom_range(0, 2) != 0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Streaming, parametrised successor to the team's fixed 8-bit parity reducer.
- Accepts WIDTH-bit words on a valid/ready input and accumulates parity across a multi-word frame ended by in_last.
- Compares the accumulated parity with the expected parity bit that arrives with the last word, then presents the result (computed parity, error, overflow, frame length) on a valid/ready output.
- Sits between a byte/word source (e.g. UART or bus receiver) and the consumer that needs per-frame integrity status.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- MAX_FRAME, 16, maximum words per frame (≥1).
- ODD, 0, parity sense: 0 = even (out_par = XOR of all bits), 1 = odd (out_par = inverted XOR).
- CNT_W, 16, error counter width (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  data word.
- in_last  input  1  word is the last of its frame.
- in_par  input  1  expected frame parity; sampled only with in_last.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_par  output  1  computed frame parity, with the ODD sense applied.
- out_err  output  1  parity mismatch, or overflow.
- out_ovf  output  1  frame truncated at MAX_FRAME words without in_last.
- out_len  output  $clog2(MAX_FRAME+1)  number of words in the frame (1..MAX_FRAME).
- err_cnt  output  CNT_W  saturating count of frames with out_err=1. Present only with PARITY_ERR_CNT_EN.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset values:
  - State is ACCUM; accumulator and word count are 0.
  - in_ready=1 after reset; out_valid, out_par, out_err, out_ovf, out_len and err_cnt are all 0.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - RESULT: in_ready=0, out_valid=1.
- Accept: a transfer happens on in_valid && in_ready. On accept, acc <= acc ^ (^in_data) and cnt <= cnt+1.
- Frame close, in ACCUM: on an accept where in_last=1, or where cnt+1 == MAX_FRAME, register the result and go to RESULT. Latency is 1 cycle: out_valid rises in the cycle after the closing word is accepted.
  - par_f = acc ^ (^in_data) ^ ODD.
  - out_par = par_f.
  - out_len = cnt+1.
  - out_ovf = ~in_last (the MAX_FRAME limit was reached with in_last=0).
  - out_err = out_ovf | (in_last & (par_f != in_par)).
- Overflow: the truncated frame reports no parity compare; out_err=1 comes from out_ovf alone. The next accepted word starts a new frame.
- A word with in_last=1 that is also word number MAX_FRAME is a normal close with out_ovf=0.
- RESULT hold: all outputs stay stable while out_valid && !out_ready.
- RESULT release: on out_ready=1, go to ACCUM with acc=0 and cnt=0. in_ready rises in the next cycle, so each frame costs one bubble. in_valid is ignored while in RESULT.
- Single-word frame (in_last on the first word) is legal: out_len=1.
- in_par is ignored on words without in_last.
- Reset mid-frame or in RESULT: the partial frame and the pending result are discarded, and no result is emitted.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- When defined:
  - err_cnt port exists.
  - err_cnt increments by 1 in the cycle the block enters RESULT with out_err=1.
  - It saturates at all-ones and clears only on rst.
- When undefined: the port and the register are absent; all other behaviour is identical.

Decomposition:
- Package parity_pkg holds:
  - state enum typedef {ACCUM, RESULT}.
  - Function par_reduce(data, odd), applying ODD after the XOR.
  - Width helper localparam computation for out_len.
- One natural sub-module: parity_word, a combinational WIDTH-parameterised XOR reduction (the generalised form of the 8-bit reducer). It is instantiated once for in_data.

Test Plan:
- Reset mid-frame: WIDTH=8, ODD=0, MAX_FRAME=16; send 0xA5 and 0x01, then rst for 1 cycle.
  - No out_valid pulse.
  - Next frame {0x03, last, in_par=0} -> out_par=0, out_err=0, out_len=1.
- Even-parity match: words {0xFF, 0x01, 0x80 last}, in_par=0.
  - out_valid one cycle after the last accept.
  - out_par=0, out_err=0, out_ovf=0, out_len=3.
- Odd mode mismatch: ODD=1, words {0x07 last}, in_par=1.
  - out_par=0, out_err=1.
  - With PARITY_ERR_CNT_EN, err_cnt=1.
- Overflow: MAX_FRAME=4, 5 words of 0x01 with in_last=0.
  - First result: out_len=4, out_ovf=1, out_err=1.
  - The 5th word starts a new frame; a following {0x00 last, in_par=1} gives out_len=2, out_par=1, out_err=0.
- Backpressure: hold out_ready=0 for 5 cycles.
  - out_valid and outputs stable, in_ready=0, and in_valid words are not consumed.
  - out_ready=1 -> in_ready=1 in the next cycle.
- Saturation: CNT_W=2 with PARITY_ERR_CNT_EN, 5 error frames -> err_cnt sequence 1, 2, 3, 3, 3.
